sum_accumulator: RTL and testbench
==================================

# sum_accumulator

Registered accumulator stage directly downstream of the 8-bit ripple adder. Each accepted beat is one 9-bit adder result: the carry out of bit 7 concatenated with the sum byte. Beats arrive over a valid/ready handshake, and the block adds COUNT consecutive beats into an ACC_W-bit total. It then presents the total, with a sticky overflow flag, on a valid/ready output port to the next consumer.

## Interface
- COUNT, default 4: beats per accumulation frame; legal range 1..255.
- ACC_W, default 12: accumulator and out_data width; must be ≥ 9.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- clear  input  1  synchronous frame abort; priority over every handshake.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_sum  input  8  sum byte from the adder.
- in_carry  input  1  final carry out (bit 7) from the adder.
- out_valid  output  1  completed frame total available.
- out_ready  input  1  downstream accepts the total.
- out_data  output  ACC_W  frame total.
- out_ovf  output  1  frame total overflowed ACC_W bits.

## Operation
- Operand is {in_carry, in_sum}, 9 bits, zero-extended to ACC_W+1 bits before the add.
- Two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- ACCUM behaviour:
  - A beat is accepted when in_valid && in_ready.
  - On accept: acc ← acc + operand, and beat counter cnt increments.
  - On the COUNT-th accept (cnt==COUNT-1): transition to HOLD and reset cnt to 0.
- HOLD behaviour:
  - out_data=acc, and out_ovf=ovf are held stable until handshake.
  - On out_valid && out_ready: acc ← 0, ovf ← 0, then return to ACCUM.
- Overflow: if the (ACC_W+1)-bit sum has its MSB set, ovf is set and stays set for the rest of the frame. The stored value follows the Configuration rule.
- clear behaviour:
  - In either state: acc ← 0, cnt ← 0, ovf ← 0, state ← ACCUM.
  - A beat or output handshake in the same cycle is discarded.
- rst_n=0: identical effect to clear. Reset wins over clear.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_ovf=0. Internally: cnt=0, state=ACCUM.
- COUNT=1: every accepted beat forms a complete frame.
- in_valid while in HOLD: the beat is not accepted, and upstream must hold it.

## Timing
- All outputs are registered or decoded directly from state. There is no combinational path from in_valid or out_ready to in_ready.
- Latency: out_valid rises on the cycle after the final beat is accepted. out_data equals the total including that beat.
- Throughput:
  - ACCUM accepts one beat per cycle.
  - A frame costs COUNT + 1 cycles minimum: COUNT beats plus ≥1 HOLD cycle.
  - in_ready rises on the cycle after the output handshake. There is no same-cycle bypass.
- out_data and out_ovf may change only in the cycle after a handshake, clear, or reset.
- Mid-frame reset or clear: the partial total is lost and no output is produced.

## Configuration
- SUM_ACC_SATURATE_EN defined:
  - On overflow, acc is forced to all ones (2^ACC_W-1).
  - Later beats in the frame leave it at all ones.
  - ovf is set.
- SUM_ACC_SATURATE_EN undefined (default):
  - acc wraps modulo 2^ACC_W.
  - ovf is set.

## Test plan
- Basic frame (COUNT=4, ACC_W=12):
  - Stimulus: four back-to-back beats {1,0xFF} (511 each).
  - Response: out_valid on the cycle after the 4th beat, out_data=0x7FC, out_ovf=0.
  - Response: in_ready=0 while out_valid=1.
- Wrap (COUNT=4, ACC_W=10, macro undefined):
  - Stimulus: four beats of 511.
  - Response: out_data=0x3FC, out_ovf=1.
  - Response: after handshake, the next frame of four beats of 0x001 gives out_data=0x004, out_ovf=0.
- Saturate (COUNT=4, ACC_W=10, SUM_ACC_SATURATE_EN defined):
  - Stimulus: four beats of 511.
  - Response: out_data=0x3FF, out_ovf=1.
- Backpressure:
  - Stimulus: complete a frame, hold out_ready=0 for 5 cycles while in_valid=1.
  - Response: out_valid=1 and out_data stable all 5 cycles, in_ready=0, no beat consumed.
  - Response: after out_ready=1 for one cycle, in_ready=1 on the next cycle.
- Clear mid-frame (COUNT=4):
  - Stimulus: two beats of 0x010, then clear=1 with in_valid=1 in the same cycle, then four beats of 0x002.
  - Response: no output from the aborted frame. The next out_data=0x008.
- Reset in HOLD:
  - Stimulus: rst_n=0 for one cycle while out_valid=1.
  - Response: next cycle out_valid=0, out_data=0, out_ovf=0, in_ready=1.
  - Response: the following four beats of 0x003 give out_data=0x00C.

Source files
------------

// File: rtl/sum_accumulator.sv
// Frame accumulator behind the 8-bit ripple adder: sums COUNT 9-bit beats, presents total + sticky overflow.
// Define SUM_ACC_SATURATE_EN to clamp the total at all ones on overflow (default build wraps).
module sum_accumulator #(
    parameter int unsigned COUNT = 4,
    parameter int unsigned ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_sum,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [7:0]       r_cnt;

    logic [ACC_W:0]   w_operand;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_beat;
    logic             w_ovf_beat;
    logic             w_beat;
    logic             w_last;
    logic             w_take;

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_HOLD);
    assign out_data  = r_acc;
    assign out_ovf   = r_ovf;

    assign w_operand  = {{(ACC_W - 8){1'b0}}, in_carry, in_sum};
    assign w_sum      = {1'b0, r_acc} + w_operand;
    assign w_ovf_beat = r_ovf | w_sum[ACC_W];
    assign w_beat     = in_valid && in_ready;
    assign w_last     = w_beat && (r_cnt == LAST_CNT);
    assign w_take     = out_valid && out_ready;

`ifdef SUM_ACC_SATURATE_EN
    // Once the frame has overflowed the total stays pinned at all ones.
    assign w_acc_beat = w_ovf_beat ? '1 : w_sum[ACC_W-1:0];
`else
    assign w_acc_beat = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_last)    w_state_nxt = ST_HOLD;
                ST_HOLD:  if (out_ready) w_state_nxt = ST_ACCUM;
                default:                 w_state_nxt = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (w_beat) begin
            r_acc <= w_acc_beat;
            r_ovf <= w_ovf_beat;
            r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
        end else if (w_take) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench: two instances (ACC_W=12 and ACC_W=10) share stimulus; a monitor pops expected totals on each output handshake.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_sum;
    logic        in_carry;
    logic        out_ready;
    logic        in_ready_a, out_valid_a, ovf_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [11:0] out_data_a;
    logic [9:0]  out_data_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    always #5 clk = ~clk;

    sum_accumulator #(.COUNT(4), .ACC_W(12)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_ovf(ovf_a)
    );

    sum_accumulator #(.COUNT(4), .ACC_W(10)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_ovf(ovf_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic ovf_12, input logic [11:0] d12, input logic ovf_10, input logic [9:0] d10);
        q_a.push_back({3'b000, ovf_12, d12});
        q_b.push_back({5'b00000, ovf_10, d10});
    endtask

    // Drives at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send_beat(input logic [8:0] v);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        {in_carry, in_sum} = v;
        for (int i = 0; i < 20; i++) begin
            if (in_ready_a) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: in_ready stayed 0, expected 1 within 20 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Monitor: every output handshake must match the next queued total.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && !clear && out_ready && out_valid_a) begin
                if (q_a.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_a_unexpected: got 0x%0h, expected no output", out_data_a);
                end else begin
                    e = q_a.pop_front();
                    check("out_a", 32'({3'b000, ovf_a, out_data_a}), 32'(e));
                end
            end
            if (rst_n && !clear && out_ready && out_valid_b) begin
                if (q_b.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_b_unexpected: got 0x%0h, expected no output", out_data_b);
                end else begin
                    e = q_b.pop_front();
                    check("out_b", 32'({5'b00000, ovf_b, out_data_b}), 32'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_sum = 8'h00; in_carry = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("reset_in_ready",  32'(in_ready_a),  32'd1);
        check("reset_out_valid", 32'(out_valid_a), 32'd0);
        check("reset_out_data",  32'(out_data_a),  32'd0);
        check("reset_out_ovf",   32'(ovf_a),       32'd0);
        check("reset_out_ovf_b", 32'(ovf_b),       32'd0);

        // Frame 1: 4 x 511 -> 0x7FC in 12 bits, overflows 10 bits.
`ifdef SUM_ACC_SATURATE_EN
        push_exp(1'b0, 12'h7FC, 1'b1, 10'h3FF);
`else
        push_exp(1'b0, 12'h7FC, 1'b1, 10'h3FC);
`endif
        repeat (4) send_beat(9'h1FF);
        check("latency_out_valid", 32'(out_valid_a), 32'd1);
        check("hold_in_ready",     32'(in_ready_a),  32'd0);
        check("hold_out_data",     32'(out_data_a),  32'h7FC);

        in_valid = 1'b1; {in_carry, in_sum} = 9'h055;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid_a), 32'd1);
            check("bp_in_ready",  32'(in_ready_a),  32'd0);
            check("bp_out_data",  32'(out_data_a),  32'h7FC);
`ifdef SUM_ACC_SATURATE_EN
            check("bp_out_data_b", 32'(out_data_b), 32'h3FF);
`else
            check("bp_out_data_b", 32'(out_data_b), 32'h3FC);
`endif
        end
        in_valid = 1'b0;
        handshake();
        check("post_hs_in_ready",  32'(in_ready_a),  32'd1);
        check("post_hs_out_valid", 32'(out_valid_a), 32'd0);

        // Frame 2: 4 x 1 with idle gaps; the wrapped frame must leave no residue.
        push_exp(1'b0, 12'h004, 1'b0, 10'h004);
        for (int i = 0; i < 4; i++) begin
            send_beat(9'h001);
            if (i < 3) idle_cycle();
        end
        check("f2_out_valid", 32'(out_valid_a), 32'd1);
        handshake();

        // Clear mid-frame, with a beat offered in the same cycle.
        push_exp(1'b0, 12'h008, 1'b0, 10'h008);
        send_beat(9'h010);
        send_beat(9'h010);
        clear = 1'b1; in_valid = 1'b1; {in_carry, in_sum} = 9'h010;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        check("clr_out_valid", 32'(out_valid_a), 32'd0);
        check("clr_in_ready",  32'(in_ready_a),  32'd1);
        check("clr_out_data",  32'(out_data_a),  32'd0);
        repeat (4) send_beat(9'h002);
        check("clr_f_out_valid", 32'(out_valid_a), 32'd1);
        handshake();

        // Reset while holding an overflowed frame: that frame is never delivered.
        repeat (4) send_beat(9'h1FF);
        in_valid = 1'b0;
        check("rh_out_valid", 32'(out_valid_a), 32'd1);
        check("rh_ovf_b",     32'(ovf_b),       32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rh_post_out_valid", 32'(out_valid_a), 32'd0);
        check("rh_post_out_data",  32'(out_data_a),  32'd0);
        check("rh_post_out_ovf",   32'(ovf_a),       32'd0);
        check("rh_post_ovf_b",     32'(ovf_b),       32'd0);
        check("rh_post_out_data_b", 32'(out_data_b), 32'd0);
        check("rh_post_in_ready",  32'(in_ready_a),  32'd1);
        push_exp(1'b0, 12'h00C, 1'b0, 10'h00C);
        repeat (4) send_beat(9'h003);
        in_valid = 1'b0;
        check("rh_f_out_valid", 32'(out_valid_a), 32'd1);
        handshake();

        repeat (3) @(posedge clk);
        #1;
        check("drain_q_a", 32'(q_a.size()), 32'd0);
        check("drain_q_b", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
